psg_multi_cpu_interface: RTL



---
 rtl/psg_multi_cpu_interface.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/psg_multi_cpu_interface.sv
// CPU write port for one or more SN76489-compatible PSG register banks.
// Decodes the latch/data byte protocol and keeps one latched-register pointer
// per bank. It holds `ready` low for WAIT_CYCLES cycles for each accepted write.
//
// Optional feature macro: PSG_STEREO_EN. It adds the Game Gear stereo pan
// register per bank, written when stereoSel = 1.
//
// Ports:
//   clock        - system clock, rising edge
//   nReset       - asynchronous active-low reset
//   d            - CPU data byte
//   sel          - target bank index (a value >= NUM_PSG runs the handshake only)
//   nCE, nWE     - active-low chip enable / write enable
//   ready        - high when a new write may start
//   freq         - 10-bit tone periods, bank b channel c at [(b*3+c)*10 +: 10]
//   att          - 4-bit attenuations, bank b at [b*16 +: 16] (tone0..2, noise)
//   noiseControl - per bank {FB, NF[1:0]}
//   noiseReset   - one-cycle pulse per bank after a noise-control write
//   stereoSel    - (PSG_STEREO_EN) route the write to the pan register
//   stereo       - (PSG_STEREO_EN) per-bank 8-bit pan register
module psg_multi_cpu_interface #(
  parameter int unsigned NUM_PSG     = 1,
  parameter int unsigned WAIT_CYCLES = 32,
  localparam int unsigned SEL_W      = (NUM_PSG > 1) ? $clog2(NUM_PSG) : 1
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic [7:0]             d,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   nCE,
  input  logic                   nWE,
  output logic                   ready,
  output logic [NUM_PSG*30-1:0]  freq,
  output logic [NUM_PSG*16-1:0]  att,
  output logic [NUM_PSG*3-1:0]   noiseControl,
  output logic [NUM_PSG-1:0]     noiseReset
`ifdef PSG_STEREO_EN
  ,
  input  logic                   stereoSel,
  output logic [NUM_PSG*8-1:0]   stereo
`endif
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, PREPARE, WAIT, FINISH} state_t;

  typedef struct packed {
    logic [1:0] ch;
    logic       typ;
  } ptr_t;

  state_t           state, state_nx;
  logic             commit_c, capture_c;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       d_q;
  logic [SEL_W-1:0] sel_q;
  ptr_t             ptr_sel, eff;

  ptr_t             ptr     [NUM_PSG];
  logic [9:0]       freq_r  [NUM_PSG][3];
  logic [3:0]       att_r   [NUM_PSG][4];
  logic [2:0]       nc_r    [NUM_PSG];
  logic [NUM_PSG-1:0] noise_rst;

`ifdef PSG_STEREO_EN
  logic             stereo_q;
  logic [7:0]       stereo_r [NUM_PSG];
`endif

  // State register, wait counter and registered ready
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
    end else begin
      state <= state_nx;
      ready <= (state_nx == IDLE) || (state_nx == FINISH);
      if (state == PREPARE)   cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
    end
  end

  // Handshake next-state logic; commit happens on the last WAIT edge
  always_comb begin
    state_nx  = state;
    commit_c  = 1'b0;
    capture_c = 1'b0;
    case (state)
      IDLE:    if (!nCE) state_nx = PREPARE;
      PREPARE: begin
        if (!nCE && !nWE) begin
          state_nx  = WAIT;
          capture_c = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(WAIT_CYCLES - 2)) begin
          state_nx = FINISH;
          commit_c = 1'b1;
        end
      end
      FINISH:  if (nCE && nWE) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Captured write
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      d_q   <= '0;
      sel_q <= '0;
`ifdef PSG_STEREO_EN
      stereo_q <= 1'b0;
`endif
    end else if (capture_c) begin
      d_q   <= d;
      sel_q <= sel;
`ifdef PSG_STEREO_EN
      stereo_q <= stereoSel;
`endif
    end
  end

  // Effective register target: a latch byte names it, a data byte reuses the pointer
  always_comb begin
    ptr_sel = '0;
    for (int b = 0; b < NUM_PSG; b++)
      if (sel_q == SEL_W'(b)) ptr_sel = ptr[b];
    eff = ptr_sel;
    if (d_q[7]) begin
      eff.ch  = d_q[6:5];
      eff.typ = d_q[4];
    end
  end

  // Register banks
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      noise_rst <= '0;
      for (int b = 0; b < NUM_PSG; b++) begin
        ptr[b]  <= '0;
        nc_r[b] <= '0;
        for (int c = 0; c < 3; c++) freq_r[b][c] <= '0;
        for (int c = 0; c < 4; c++) att_r[b][c]  <= 4'hF;
`ifdef PSG_STEREO_EN
        stereo_r[b] <= 8'hFF;
`endif
      end
    end else begin
      noise_rst <= '0;
      if (commit_c) begin
        for (int b = 0; b < NUM_PSG; b++) begin
          if (sel_q == SEL_W'(b)) begin
`ifdef PSG_STEREO_EN
            if (stereo_q) begin
              stereo_r[b] <= d_q;
            end else
`endif
            begin
              if (d_q[7]) ptr[b] <= eff;
              if (eff.typ) begin
                att_r[b][eff.ch] <= d_q[3:0];
              end else if (eff.ch == 2'd3) begin
                nc_r[b]      <= d_q[2:0];
                noise_rst[b] <= 1'b1;
              end else begin
                for (int c = 0; c < 3; c++) begin
                  if (eff.ch == 2'(c)) begin
                    if (d_q[7]) freq_r[b][c][3:0] <= d_q[3:0];
                    else        freq_r[b][c][9:4] <= d_q[5:0];
                  end
                end
              end
            end
          end
        end
      end
    end
  end

  // Flatten register arrays onto the output buses
  for (genvar b = 0; b < NUM_PSG; b++) begin : g_bank
    for (genvar c = 0; c < 3; c++) begin : g_tone
      assign freq[(b*3+c)*10 +: 10] = freq_r[b][c];
    end
    for (genvar c = 0; c < 4; c++) begin : g_att
      assign att[b*16 + c*4 +: 4] = att_r[b][c];
    end
    assign noiseControl[b*3 +: 3] = nc_r[b];
`ifdef PSG_STEREO_EN
    assign stereo[b*8 +: 8] = stereo_r[b];
`endif
  end

  assign noiseReset = noise_rst;

endmodule
